motor_ctrl_multi: RTL and testbench

//   Multi-channel motor control core: NUM_CH independent PWM generators and encoder speed counters

---
 rtl/motor_ctrl_multi.sv | 200 ++++++++++++++++++++
 tb/tb_motor_ctrl_multi.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_ctrl_multi.sv
// rtl/motor_ctrl_multi.sv - multi-channel PWM generators and encoder speed counters behind a register port
// Build option: define SPEED_AVG_EN to average each new speed sample with the previous SPEED value.
module motor_ctrl_multi #(
  parameter int NUM_CH          = 4,
  parameter int CLK_PERIOD      = 100,
  parameter int PPR             = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int REG_UPDATE_FREQ = 10,
  localparam int ADDR_WIDTH     = $clog2(NUM_CH) + 2
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  writeValid,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic                  writeResponse,
  output logic                  writeError,
  input  logic                  readValid,
  input  logic [ADDR_WIDTH-1:0] readAddress,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  readDataValid,
  input  logic [NUM_CH-1:0]     pulseData,
  output logic [NUM_CH-1:0]     PWM
);

  localparam int GATE = 1000000000 / (CLK_PERIOD * REG_UPDATE_FREQ);
  localparam int GW   = (GATE > 1) ? $clog2(GATE) : 1;
  localparam int MW   = DATA_WIDTH + 8;
  localparam logic [1:0] REG_SPEED  = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_DUTY   = 2'd2;

  logic [DATA_WIDTH-1:0] period_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] duty_q    [NUM_CH];
  logic [NUM_CH-1:0]     en_q;
  logic [DATA_WIDTH-1:0] per_sh_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] duty_sh_q [NUM_CH];
  logic [DATA_WIDTH-1:0] cnt_q     [NUM_CH];
  logic [NUM_CH-1:0]     pwm_q;
  logic [NUM_CH-1:0]     sync1_q, sync2_q, prev_q;
  logic [GW-1:0]         gate_q;
  logic [DATA_WIDTH-1:0] edges_q   [NUM_CH];
  logic [DATA_WIDTH-1:0] edges_d   [NUM_CH];
  logic [DATA_WIDTH-1:0] speed_q   [NUM_CH];
  logic [DATA_WIDTH-1:0] sample_d  [NUM_CH];
  logic [MW-1:0]         scaled;
  logic                  wresp_q, werr_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [31:0]           wr_idx, rd_idx;
  logic [1:0]            wr_reg, rd_reg;
  logic                  wr_ok, gate_end;
  logic [NUM_CH-1:0]     rise;
`ifdef SPEED_AVG_EN
  logic                  primed_q;
`endif

  // Address split: upper bits select the channel (may exceed NUM_CH), low two bits the register
  assign wr_idx   = 32'(writeAddress >> 2);
  assign rd_idx   = 32'(readAddress >> 2);
  assign wr_reg   = writeAddress[1:0];
  assign rd_reg   = readAddress[1:0];
  assign wr_ok    = (wr_idx < NUM_CH) && (wr_reg != REG_SPEED);
  assign gate_end = (gate_q == GW'(GATE - 1));
  assign rise     = sync2_q & ~prev_q;

  // Register file writes; SPEED and absent channels are never modified
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int c = 0; c < NUM_CH; c++) begin
        period_q[c] <= '0;
        duty_q[c]   <= '0;
      end
      en_q <= '0;
    end else if (writeValid && wr_ok) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_idx == c) begin
          case (wr_reg)
            REG_PERIOD: period_q[c] <= writeData;
            REG_DUTY:   duty_q[c]   <= writeData;
            default:    en_q[c]     <= writeData[0];
          endcase
        end
      end
    end
  end

  // Read mux; absent channels read as zero
  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_idx == c) begin
        case (rd_reg)
          REG_SPEED:  rdata_d = speed_q[c];
          REG_PERIOD: rdata_d = period_q[c];
          REG_DUTY:   rdata_d = duty_q[c];
          default:    rdata_d = DATA_WIDTH'(en_q[c]);
        endcase
      end
    end
  end

  // Handshake outputs one cycle after the request edge; read data holds until the next read
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wresp_q  <= 1'b0;
      werr_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wresp_q  <= writeValid;
      werr_q   <= writeValid && !wr_ok;
      rvalid_q <= readValid;
      if (readValid) rdata_q <= rdata_d;
    end
  end

  // PWM counters; shadows reload only at period wrap or while the channel is idle so updates never glitch
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int c = 0; c < NUM_CH; c++) begin
        per_sh_q[c]  <= '0;
        duty_sh_q[c] <= '0;
        cnt_q[c]     <= '0;
      end
      pwm_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!en_q[c] || per_sh_q[c] == '0) begin
          cnt_q[c]     <= '0;
          pwm_q[c]     <= 1'b0;
          per_sh_q[c]  <= period_q[c];
          duty_sh_q[c] <= duty_q[c];
        end else begin
          pwm_q[c] <= (cnt_q[c] < duty_sh_q[c]);
          if (cnt_q[c] == per_sh_q[c] - DATA_WIDTH'(1)) begin
            cnt_q[c]     <= '0;
            per_sh_q[c]  <= period_q[c];
            duty_sh_q[c] <= duty_q[c];
          end else begin
            cnt_q[c] <= cnt_q[c] + DATA_WIDTH'(1);
          end
        end
      end
    end
  end

  // Window edge total (saturating, includes an edge on the gate-end cycle) and rpm conversion
  always_comb begin
    scaled = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      edges_d[c]  = (rise[c] && edges_q[c] != '1) ? edges_q[c] + DATA_WIDTH'(1) : edges_q[c];
      scaled      = (MW'(edges_d[c]) * MW'(60 * REG_UPDATE_FREQ)) / MW'(PPR);
      sample_d[c] = (scaled > MW'({DATA_WIDTH{1'b1}})) ? '1 : scaled[DATA_WIDTH-1:0];
    end
  end

  // Pulse synchronisers, shared gate counter and per-channel speed capture at gate end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      gate_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        edges_q[c] <= '0;
        speed_q[c] <= '0;
      end
`ifdef SPEED_AVG_EN
      primed_q <= 1'b0;
`endif
    end else begin
      sync1_q <= pulseData;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      gate_q  <= gate_end ? '0 : gate_q + GW'(1);
`ifdef SPEED_AVG_EN
      if (gate_end) primed_q <= 1'b1;
`endif
      for (int c = 0; c < NUM_CH; c++) begin
        if (gate_end) begin
          edges_q[c] <= '0;
`ifdef SPEED_AVG_EN
          speed_q[c] <= primed_q ? DATA_WIDTH'((MW'(speed_q[c]) + MW'(sample_d[c])) >> 1) : sample_d[c];
`else
          speed_q[c] <= sample_d[c];
`endif
        end else begin
          edges_q[c] <= edges_d[c];
        end
      end
    end
  end

  assign writeResponse = wresp_q;
  assign writeError    = werr_q;
  assign readDataValid = rvalid_q;
  assign readData      = rdata_q;
  assign PWM           = pwm_q;

endmodule

// File: tb/tb_motor_ctrl_multi.sv
// tb/tb_motor_ctrl_multi.sv - directed scoreboard bench for motor_ctrl_multi
module tb_motor_ctrl_multi;

  localparam int FREQ = 1000;
  localparam int GATE = 10000;
  localparam int AW   = 4;
  localparam int AWB  = 5;
  localparam int SAMPLE = 100 * 60 * FREQ / 10;
`ifdef SPEED_AVG_EN
  localparam int EXP_W2 = (0 + SAMPLE) >> 1;
  localparam int EXP_W3 = (EXP_W2 + 0) >> 1;
`else
  localparam int EXP_W2 = SAMPLE;
  localparam int EXP_W3 = 0;
`endif

  logic          clk = 1'b0;
  logic          rstN;
  logic          writeValid, readValid;
  logic [AW-1:0] writeAddress, readAddress;
  logic [31:0]   writeData, readData;
  logic          writeResponse, writeError, readDataValid;
  logic [3:0]    pulseData, PWM;

  logic           b_wvalid, b_rvalid;
  logic [AWB-1:0] b_waddr, b_raddr;
  logic [31:0]    b_wdata, b_rdata;
  logic           b_wresp, b_werr, b_rdv;
  logic [4:0]     b_pulse, b_pwm;

  int checks   = 0;
  int failures = 0;
  int cyc;
  logic [31:0] rd_q[$];
  logic        wr_q[$];

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstN)
    if (!rstN) cyc <= 0;
    else       cyc <= cyc + 1;

  motor_ctrl_multi #(.NUM_CH(4), .REG_UPDATE_FREQ(FREQ)) dut (
    .clk(clk), .rstN(rstN),
    .writeValid(writeValid), .writeAddress(writeAddress), .writeData(writeData),
    .writeResponse(writeResponse), .writeError(writeError),
    .readValid(readValid), .readAddress(readAddress), .readData(readData),
    .readDataValid(readDataValid), .pulseData(pulseData), .PWM(PWM)
  );

  motor_ctrl_multi #(.NUM_CH(5), .REG_UPDATE_FREQ(FREQ)) dut_b (
    .clk(clk), .rstN(rstN),
    .writeValid(b_wvalid), .writeAddress(b_waddr), .writeData(b_wdata),
    .writeResponse(b_wresp), .writeError(b_werr),
    .readValid(b_rvalid), .readAddress(b_raddr), .readData(b_rdata),
    .readDataValid(b_rdv), .pulseData(b_pulse), .PWM(b_pwm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    int guard = 0;
    while (cyc < n && guard < 50000) begin
      tick();
      guard++;
    end
    if (cyc < n) check("wait_bound", cyc, n);
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [31:0] d, input logic err);
    wr_q.push_back(err);
    writeValid = 1'b1; writeAddress = a; writeData = d;
    tick();
    writeValid = 1'b0;
    check("wresp", writeResponse, 1);
    check("werr", writeError, wr_q.pop_front());
  endtask

  task automatic rd_a(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    rd_q.push_back(exp);
    readValid = 1'b1; readAddress = a;
    tick();
    readValid = 1'b0;
    check({tag, "_valid"}, readDataValid, 1);
    e = rd_q.pop_front();
    check(tag, readData, e);
    tick();
    check({tag, "_pulse"}, readDataValid, 0);
    check({tag, "_hold"}, readData, e);
  endtask

  task automatic rw_a(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] exp);
    rd_q.push_back(exp);
    wr_q.push_back(1'b0);
    writeValid = 1'b1; writeAddress = a; writeData = d;
    readValid  = 1'b1; readAddress  = a;
    tick();
    writeValid = 1'b0; readValid = 1'b0;
    check("rw_wresp", writeResponse, 1);
    check("rw_werr", writeError, wr_q.pop_front());
    check("rw_rvalid", readDataValid, 1);
    check("rw_old", readData, rd_q.pop_front());
  endtask

  task automatic wr_b(input logic [AWB-1:0] a, input logic [31:0] d, input logic err);
    wr_q.push_back(err);
    b_wvalid = 1'b1; b_waddr = a; b_wdata = d;
    tick();
    b_wvalid = 1'b0;
    check("b_wresp", b_wresp, 1);
    check("b_werr", b_werr, wr_q.pop_front());
  endtask

  task automatic rd_b(input logic [AWB-1:0] a, input logic [31:0] exp, input string tag);
    rd_q.push_back(exp);
    b_rvalid = 1'b1; b_raddr = a;
    tick();
    b_rvalid = 1'b0;
    check({tag, "_valid"}, b_rdv, 1);
    check(tag, b_rdata, rd_q.pop_front());
  endtask

  initial begin
    logic e;
    rstN = 1'b0;
    writeValid = 1'b0; writeAddress = '0; writeData = '0;
    readValid = 1'b0; readAddress = '0; pulseData = '0;
    b_wvalid = 1'b0; b_waddr = '0; b_wdata = '0;
    b_rvalid = 1'b0; b_raddr = '0; b_pulse = '0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    check("rst_pwm", PWM, 0);
    check("rst_wresp", writeResponse, 0);
    check("rst_rvalid", readDataValid, 0);
    check("rst_rdata", readData, 0);
    rd_a(4'd0, 0, "spd0_rst");

    // ch1: PERIOD=10 DUTY=3 EN=1, DUTY->7 mid-period
    wr_a(4'd5, 10, 1'b0);
    wr_a(4'd6, 3, 1'b0);
    wr_a(4'd7, 1, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      if (k == 6) wr_a(4'd6, 7, 1'b0);
      else        tick();
      e = (((k - 1) % 10) < (((k - 1) / 10 == 0) ? 3 : 7));
      check("pwm1", PWM[1], e);
      check("pwm_others", PWM & 4'b1101, 0);
    end
    rd_a(4'd6, 7, "duty1");
    rd_a(4'd7, 1, "ctrl1");

    // decode errors
    wr_a(4'd0, 32'h1234, 1'b1);
    rd_a(4'd0, 0, "spd0_ro");
    wr_b(5'd21, 32'h55, 1'b1);
    rd_b(5'd5, 0, "b_ch1_per");
    wr_b(5'd17, 9, 1'b0);
    rd_b(5'd17, 9, "b_ch4_per");
    rd_b(5'd21, 0, "b_ch5_rd");
    check("b_pwm", b_pwm, 0);

    // simultaneous read and write of one register returns the old value
    wr_a(4'd13, 5, 1'b0);
    rw_a(4'd13, 12, 5);
    rd_a(4'd13, 12, "per3_new");

    // speed: 100 edges on ch2 inside the second gate window only
    for (int i = 0; i < 100; i++) begin
      wait_until(GATE + 10 + 100 * i);
      pulseData[2] = 1'b1;
      wait_until(GATE + 60 + 100 * i);
      pulseData[2] = 1'b0;
    end
    wait_until(2 * GATE + 2);
    rd_a(4'd8, EXP_W2, "spd2_w2");
    rd_a(4'd12, 0, "spd3_idle");
    wait_until(3 * GATE + 2);
    rd_a(4'd8, EXP_W3, "spd2_w3");

    // reset mid-period with DUTY=PERIOD=8
    wr_a(4'd1, 8, 1'b0);
    wr_a(4'd2, 8, 1'b0);
    wr_a(4'd3, 1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k > 0) check("pwm0_full", PWM[0], 1);
    end
    #3 rstN = 1'b0;
    #1;
    check("pwm_async_rst", PWM, 0);
    check("rvalid_async_rst", readDataValid, 0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("pwm0_after_rst", PWM[0], 0);
    end
    rd_a(4'd1, 0, "per0_after_rst");
    rd_a(4'd3, 0, "ctrl0_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
